// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the fp16 arithmetic datapath (divider, multiplier).
// Field layout, special encodings, operand classes and the divider FSM states.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int BIAS   = 15;
    localparam int ITER   = MAN_W + 4;
    localparam int CNT_W  = $clog2(ITER);
    localparam int SEXP_W = EXP_W + 2;

    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [15:0] POS_INF = 16'h7C00;
    localparam logic [15:0] NEG_INF = 16'hFC00;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
    } fp16_t;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } op_class_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_DIVIDE,
        ST_ROUND
    } state_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational unpack of one binary16 operand into class, sign, exponent and
// 11-bit significand; subnormals are flushed and reported as zero.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0]      i_op,
    output logic [1:0]       o_cls,
    output logic             o_sign,
    output logic [EXP_W-1:0] o_exp,
    output logic [MAN_W:0]   o_sig
);

    fp16_t w_f;

    assign w_f    = i_op;
    assign o_sign = w_f.s;
    assign o_exp  = w_f.e;

    always_comb begin
        o_cls = NORM;
        o_sig = {1'b1, w_f.m};
        if (w_f.e == '0) begin
            // zero and subnormal share one class; the fraction is dropped
            o_cls = ZERO;
            o_sig = '0;
        end else if (w_f.e == '1) begin
            o_cls = (w_f.m == '0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp16_div_seq.sv
// Sequential binary16 divider: radix-2 restoring mantissa division, fixed latency,
// round to nearest even, no subnormal output. start/busy/done handshake.
module fp16_div_seq
    import fp16_pkg::*;
(
    input  logic        clk_44,
    input  logic        reset_44,
    input  logic        start_44,
    input  logic [15:0] divIn1_44,
    input  logic [15:0] divIn2_44,
    output logic [15:0] divOut_44,
    output logic        busy_44,
    output logic        d_o_44,
    output logic [1:0]  dbg_state_44
);

    localparam logic signed [SEXP_W-1:0] SE_ZERO = '0;
    localparam logic signed [SEXP_W-1:0] SE_ONE  = SEXP_W'(1);
    localparam logic signed [SEXP_W-1:0] SE_MAX  = SEXP_W'(31);
    localparam logic signed [SEXP_W-1:0] SE_BIAS = SEXP_W'(BIAS);
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(ITER - 1);

    state_t r_state;
    state_t w_next;

    logic w_load;
    logic w_unpack;
    logic w_iter;
    logic w_finish;

    logic [15:0]              r_a;
    logic [15:0]              r_b;
    logic                     r_sign;
    logic signed [SEXP_W-1:0] r_exp;
    logic [MAN_W+1:0]         r_rem;
    logic [MAN_W:0]           r_mb;
    logic [ITER-1:0]          r_q;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_special;
    logic [15:0]              r_spec_val;
    logic [15:0]              r_out;
    logic                     r_done;

    logic [1:0]       w_cls_a;
    logic [1:0]       w_cls_b;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [EXP_W-1:0] w_exp_a;
    logic [EXP_W-1:0] w_exp_b;
    logic [MAN_W:0]   w_sig_a;
    logic [MAN_W:0]   w_sig_b;

    fp16_classify u_cls_a (
        .i_op   (r_a),
        .o_cls  (w_cls_a),
        .o_sign (w_sign_a),
        .o_exp  (w_exp_a),
        .o_sig  (w_sig_a)
    );

    fp16_classify u_cls_b (
        .i_op   (r_b),
        .o_cls  (w_cls_b),
        .o_sign (w_sign_b),
        .o_exp  (w_exp_b),
        .o_sig  (w_sig_b)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_44 or posedge reset_44) begin
        if (reset_44) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start_44) w_next = ST_UNPACK;
            ST_UNPACK: w_next = ST_DIVIDE;
            ST_DIVIDE: if (r_cnt == CNT_LAST) w_next = ST_ROUND;
            ST_ROUND:  w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / datapath enables ----------------
    always_comb begin
        w_load   = 1'b0;
        w_unpack = 1'b0;
        w_iter   = 1'b0;
        w_finish = 1'b0;
        busy_44  = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:   w_load   = start_44;
            ST_UNPACK: w_unpack = 1'b1;
            ST_DIVIDE: w_iter   = 1'b1;
            ST_ROUND:  w_finish = 1'b1;
            default:   w_load   = 1'b0;
        endcase
    end

    assign dbg_state_44 = r_state;
    assign divOut_44    = r_out;
    assign d_o_44       = r_done;

    // ---------------- unpack: sign, exponent, special results ----------------
    logic                     w_sign;
    logic signed [SEXP_W-1:0] w_exp_diff;
    logic                     w_special;
    logic [15:0]              w_spec_val;

    assign w_sign     = w_sign_a ^ w_sign_b;
    assign w_exp_diff = $signed({2'b00, w_exp_a}) - $signed({2'b00, w_exp_b}) + SE_BIAS;

    always_comb begin
        w_special  = 1'b1;
        w_spec_val = QNAN;
        if (w_cls_a == NAN || w_cls_b == NAN ||
            (w_cls_a == ZERO && w_cls_b == ZERO) ||
            (w_cls_a == INF && w_cls_b == INF)) begin
            w_spec_val = QNAN;
        end else if (w_cls_a == INF || w_cls_b == ZERO) begin
            w_spec_val = w_sign ? NEG_INF : POS_INF;
        end else if (w_cls_a == ZERO || w_cls_b == INF) begin
            w_spec_val = {w_sign, 15'h0000};
        end else begin
            w_special = 1'b0;
        end
    end

    // ---------------- restoring divide step ----------------
    logic             w_ge;
    logic [MAN_W+1:0] w_diff;
    logic [MAN_W+1:0] w_rem_sel;
    logic [MAN_W+1:0] w_rem_next;

    assign w_ge       = (r_rem >= {1'b0, r_mb});
    assign w_diff     = r_rem - {1'b0, r_mb};
    assign w_rem_sel  = w_ge ? w_diff : r_rem;
    // the partial remainder is always below mb, so the shifted-out bit is zero
    assign w_rem_next = w_rem_sel << 1;

    // ---------------- normalise and round ----------------
    logic [ITER-1:0]          w_qn;
    logic signed [SEXP_W-1:0] w_exp_n;
    logic signed [SEXP_W-1:0] w_exp_r;
    logic [MAN_W:0]           w_mant;
    logic                     w_guard;
    logic                     w_sticky;
    logic                     w_up;
    logic [MAN_W+1:0]         w_sum;
    logic [MAN_W-1:0]         w_frac;
    logic [15:0]              w_result;

    always_comb begin
        if (r_q[ITER-1]) begin
            w_qn    = r_q;
            w_exp_n = r_exp;
        end else begin
            w_qn    = {r_q[ITER-2:0], 1'b0};
            w_exp_n = r_exp - SE_ONE;
        end
        w_mant   = w_qn[ITER-1 -: MAN_W+1];
        w_guard  = w_qn[2];
        w_sticky = w_qn[1] | w_qn[0] | (r_rem != '0);
        w_up     = w_guard & (w_sticky | w_mant[0]);
        w_sum    = {1'b0, w_mant} + {{(MAN_W+1){1'b0}}, w_up};
        // a carry out of the significand leaves 1.000... one binade higher
        if (w_sum[MAN_W+1]) begin
            w_exp_r = w_exp_n + SE_ONE;
            w_frac  = w_sum[MAN_W:1];
        end else begin
            w_exp_r = w_exp_n;
            w_frac  = w_sum[MAN_W-1:0];
        end

        if (r_special) begin
            w_result = r_spec_val;
        end else if (w_exp_r >= SE_MAX) begin
            w_result = r_sign ? NEG_INF : POS_INF;
        end else if (w_exp_r <= SE_ZERO) begin
            w_result = {r_sign, 15'h0000};
        end else begin
            w_result = {r_sign, w_exp_r[EXP_W-1:0], w_frac};
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_44 or posedge reset_44) begin
        if (reset_44) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_rem      <= '0;
            r_mb       <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_out      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_a <= divIn1_44;
                r_b <= divIn2_44;
            end
            if (w_unpack) begin
                r_sign     <= w_sign;
                r_exp      <= w_exp_diff;
                r_rem      <= {1'b0, w_sig_a};
                r_mb       <= w_sig_b;
                r_q        <= '0;
                r_cnt      <= '0;
                r_special  <= w_special;
                r_spec_val <= w_spec_val;
            end
            if (w_iter) begin
                r_rem <= w_rem_next;
                r_q   <= {r_q[ITER-2:0], w_ge};
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_finish) begin
                r_out  <= w_result;
                r_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp16_div_seq.sv
// Bench for fp16_div_seq: directed cases, handshake and reset-abort scenarios,
// then random operands against an exact-arithmetic reference of binary16 division.
module tb_fp16_div_seq;

    localparam int LAT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic [15:0] div_out;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    fp16_div_seq dut (
        .clk_44       (clk),
        .reset_44     (rst),
        .start_44     (start),
        .divIn1_44    (a_in),
        .divIn2_44    (b_in),
        .divOut_44    (div_out),
        .busy_44      (busy),
        .d_o_44       (done),
        .dbg_state_44 (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] exp_q[$];
    int          due_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] last_want = '0;
    logic [15:0] mon_want;
    int          mon_due;

    logic [15:0] spec_ops [6] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E01, 16'h0201};

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec = n_vec + 1;
        if (got !== want) begin
            n_miss = n_miss + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec = n_vec + 1;
        if (got != want) begin
            n_miss = n_miss + 1;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Exact rational quotient, rounded to 11 significant bits (nearest, ties to even).
    function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        logic   s;
        int     ea, eb, e, p;
        longint ma, mb, num, q, r, rest, half, mant, one;
        bit     a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
        s      = a[15] ^ b[15];
        ea     = int'(a[14:10]);
        eb     = int'(b[14:10]);
        a_nan  = (ea == 31) && (a[9:0] != 0);
        a_inf  = (ea == 31) && (a[9:0] == 0);
        a_zero = (ea == 0);
        b_nan  = (eb == 31) && (b[9:0] != 0);
        b_inf  = (eb == 31) && (b[9:0] == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 16'h7E00;
        if (a_inf || b_zero) return {s, 5'h1F, 10'h000};
        if (a_zero || b_inf) return {s, 15'h0000};
        one  = 1;
        ma   = 1024 + longint'(a[9:0]);
        mb   = 1024 + longint'(b[9:0]);
        num  = ma << 40;
        q    = num / mb;
        r    = num % mb;
        p    = (q >= (one << 40)) ? 40 : 39;
        e    = ea - eb + 15 + (p - 40);
        mant = q >> (p - 10);
        rest = q - (mant << (p - 10));
        half = one << (p - 11);
        if (rest > half || (rest == half && (r != 0 || mant % 2 == 1))) mant = mant + 1;
        if (mant == 2048) begin
            mant = 1024;
            e    = e + 1;
        end
        if (e >= 31) return {s, 5'h1F, 10'h000};
        if (e <= 0) return {s, 15'h0000};
        return {s, e[4:0], mant[9:0]};
    endfunction

    function automatic logic [15:0] rnd_op();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return 16'($urandom);
        if (k == 1) return spec_ops[$urandom_range(0, 5)];
        return {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
    endfunction

    // Called on a negedge; waits for idle, drives one start cycle, returns on the next negedge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] want, input bit push);
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 100) begin
            @(negedge clk);
            w = w + 1;
        end
        if (w >= 100) begin
            n_vec  = n_vec + 1;
            n_miss = n_miss + 1;
            $display("FAIL idle_wait busy=%b want=0", busy);
        end
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        if (push) begin
            exp_q.push_back(want);
            due_q.push_back(cyc + LAT + 1);
            last_want = want;
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {15'h0, busy}, 16'h0001);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w = w + 1;
        end
        if (exp_q.size() != 0) begin
            n_vec  = n_vec + 1;
            n_miss = n_miss + 1;
            $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
            exp_q.delete();
            due_q.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_vec  = n_vec + 1;
                n_miss = n_miss + 1;
                $display("FAIL unexpected_done got=%h want=no_pulse", div_out);
            end else begin
                mon_want = exp_q.pop_front();
                mon_due  = due_q.pop_front();
                check("result", div_out, mon_want);
                check_int("latency_cycle", cyc, mon_due);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time_limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        #2;
        check("reset_out", div_out, 16'h0000);
        check("reset_busy", {15'h0, busy}, 16'h0000);
        check("reset_done", {15'h0, done}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // directed values, issued back to back (each start lands in the done cycle)
        issue(16'hAA66, 16'hB800, 16'h2E66, 1'b1);
        issue(16'h3C00, 16'h4200, 16'h3555, 1'b1);
        issue(16'h3C00, 16'h0000, 16'h7C00, 1'b1);
        issue(16'h0000, 16'h0000, 16'h7E00, 1'b1);
        issue(16'hFC00, 16'h4000, 16'hFC00, 1'b1);
        issue(16'h4000, 16'h7C00, 16'h0000, 1'b1);
        issue(16'h7BFF, 16'h3800, 16'h7C00, 1'b1);
        issue(16'h0400, 16'h4800, 16'h0000, 1'b1);
        issue(16'h4600, 16'h4000, 16'h4200, 1'b1);
        drain();

        // second start three cycles in must be ignored
        issue(16'hAA66, 16'hB800, 16'h2E66, 1'b1);
        repeat (2) @(negedge clk);
        a_in  = 16'h3C00;
        b_in  = 16'h4200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // reset in the middle of DIVIDE aborts without a done pulse
        issue(16'h4600, 16'h4000, 16'h4200, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out", div_out, 16'h0000);
        check("abort_busy", {15'h0, busy}, 16'h0000);
        check("abort_done", {15'h0, done}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(16'h3C00, 16'h4200, 16'h3555, 1'b1);
        drain();

        for (int i = 0; i < 200; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            issue(ra, rb, ref_div(ra, rb), 1'b1);
        end
        drain();

        repeat (3) @(negedge clk);
        check("result_hold", div_out, last_want);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
